// File: rtl/bus_arbiter.sv
// Two-master Wishbone-classic arbiter: MEM-stage load/store has fixed priority over
// instruction fetch; single transfers, registered acknowledges, in-flight fetch discard.
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                flush_i,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ack_o,
  output logic                stallreq_if_o,
  output logic                stallreq_mem_o,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_sel_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t state, state_nxt;
  logic   discard;
  logic   grant_d, grant_i, done_d, done_i, deliver_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d) state_nxt = BUSY_D;
               else if (grant_i) state_nxt = BUSY_I;
      BUSY_D:  if (m_ack_i) state_nxt = IDLE;
      BUSY_I:  if (m_ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A port whose ack is high this cycle is still presenting the request just served.
  always_comb begin
    grant_d   = (state == IDLE) && d_req_i && !d_ack_o;
    grant_i   = (state == IDLE) && !grant_d && if_req_i && !if_ack_o && !flush_i;
    done_d    = (state == BUSY_D) && m_ack_i;
    done_i    = (state == BUSY_I) && m_ack_i;
    deliver_i = done_i && !discard && !flush_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
    end else if (grant_d) begin
      m_cyc_o   <= 1'b1;
      m_stb_o   <= 1'b1;
      m_we_o    <= d_we_i;
      m_sel_o   <= d_sel_i;
      m_addr_o  <= d_addr_i;
      m_wdata_o <= d_wdata_i;
    end else if (grant_i) begin
      m_cyc_o   <= 1'b1;
      m_stb_o   <= 1'b1;
      m_we_o    <= 1'b0;
      m_sel_o   <= '1;
      m_addr_o  <= if_addr_i;
    end else if (done_d || done_i) begin
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
    end
  end

  // A fetch flushed at any point of its bus cycle still completes on the bus but is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_ack_o    <= 1'b0;
      if_ack_o   <= 1'b0;
      d_rdata_o  <= '0;
      if_rdata_o <= '0;
      discard    <= 1'b0;
    end else begin
      d_ack_o  <= done_d;
      if_ack_o <= deliver_i;
      if (done_d && !m_we_o) d_rdata_o <= m_rdata_i;
      if (deliver_i) if_rdata_o <= m_rdata_i;
      if (done_i) discard <= 1'b0;
      else if (state == BUSY_I && flush_i) discard <= 1'b1;
    end
  end

  assign stallreq_if_o  = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = d_req_i & ~d_ack_o;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios then random two-master traffic, all checked
// every cycle against a transfer-level model with a wait-state Wishbone slave.
module tb_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req_i = 1'b0, flush_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              d_req_i = 1'b0, d_we_i = 1'b0;
  logic [3:0]        d_sel_i = '0;
  logic [ADDR_W-1:0] d_addr_i = '0;
  logic [DATA_W-1:0] d_wdata_i = '0, d_rdata_o;
  logic              d_ack_o, stallreq_if_o, stallreq_mem_o;
  logic              m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]        m_sel_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic [DATA_W-1:0] m_rdata_i = '0;
  logic              m_ack_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .flush_i(flush_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i)
  );

  always #5 clk = ~clk;

  // Slave and master knobs
  int fixed_ws = 0, cur_ws = 0, ws_cnt = 0;
  bit rand_ws = 0, force_ack = 0, auto_release = 1;

  // Transfer-level model: who owns the bus, whether the fetch was flushed, last read data
  int          owner = 0;
  bit          killed = 0, model_valid = 0;
  logic        cur_we = 1'b0;
  logic [3:0]  cur_sel = '0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, exp_d_rdata = '0, exp_if_rdata = '0;
  logic        exp_stb = 1'b0, exp_dack = 1'b0, exp_iack = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h2402_0005;
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a falling edge once the masters have set this cycle's inputs.
  task automatic cycle();
    logic n_dack, n_iack;
    if (auto_release && d_ack_o === 1'b1) d_req_i = 1'b0;
    if (auto_release && if_ack_o === 1'b1) if_req_i = 1'b0;
    #1;
    if (model_valid) begin
      check("d_ack", 32'(d_ack_o), 32'(exp_dack));
      check("if_ack", 32'(if_ack_o), 32'(exp_iack));
      check("d_rdata", d_rdata_o, exp_d_rdata);
      check("if_rdata", if_rdata_o, exp_if_rdata);
      check("m_cyc", 32'(m_cyc_o), 32'(exp_stb));
      check("m_stb", 32'(m_stb_o), 32'(exp_stb));
      check("stall_if", 32'(stallreq_if_o), 32'(if_req_i & ~exp_iack));
      check("stall_mem", 32'(stallreq_mem_o), 32'(d_req_i & ~exp_dack));
      if (exp_stb) begin
        check("m_we", 32'(m_we_o), 32'(cur_we));
        check("m_sel", 32'(m_sel_o), 32'(cur_sel));
        check("m_addr", m_addr_o, cur_addr);
        if (cur_we) check("m_wdata", m_wdata_o, cur_wdata);
      end
    end
    if (force_ack) begin
      m_ack_i = 1'b1; m_rdata_i = $urandom; ws_cnt = 0;
    end else if (m_ack_i) begin
      m_ack_i = 1'b0; m_rdata_i = $urandom;
    end else if (m_cyc_o === 1'b1 && m_stb_o === 1'b1) begin
      if (ws_cnt >= cur_ws) begin
        m_ack_i = 1'b1;
        m_rdata_i = m_we_o ? $urandom : mem_data(m_addr_o);
        ws_cnt = 0;
      end else begin
        ws_cnt++; m_rdata_i = $urandom;
      end
    end else begin
      ws_cnt = 0;
      cur_ws = rand_ws ? int'($urandom_range(0, 3)) : fixed_ws;
      m_rdata_i = $urandom;
    end
    n_dack = 1'b0;
    n_iack = 1'b0;
    if (rst) begin
      owner = 0; killed = 0; cur_we = 1'b0; cur_sel = '0; cur_addr = '0; cur_wdata = '0;
      exp_d_rdata = '0; exp_if_rdata = '0; model_valid = 1;
    end else if (model_valid) begin
      case (owner)
        1: if (m_ack_i) begin
             owner = 0; n_dack = 1'b1;
             if (!cur_we) exp_d_rdata = m_rdata_i;
           end
        2: begin
             if (flush_i) killed = 1;
             if (m_ack_i) begin
               owner = 0;
               if (!killed) begin n_iack = 1'b1; exp_if_rdata = m_rdata_i; end
               killed = 0;
             end
           end
        default:
          if (d_req_i && !exp_dack) begin
            owner = 1; cur_we = d_we_i; cur_sel = d_sel_i; cur_addr = d_addr_i; cur_wdata = d_wdata_i;
          end else if (if_req_i && !exp_iack && !flush_i) begin
            owner = 2; cur_we = 1'b0; cur_sel = 4'hF; cur_addr = if_addr_i;
          end
      endcase
    end
    exp_dack = n_dack;
    exp_iack = n_iack;
    exp_stb  = (owner != 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("reset m_stb", 32'(m_stb_o), 32'd0);
    check("reset d_ack", 32'(d_ack_o), 32'd0);
    check("reset m_addr", m_addr_o, 32'd0);

    // Fetch only, zero-wait slave
    fixed_ws = 0;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    cycle();
    check("t1 stb c1", 32'(m_stb_o), 32'd1);
    check("t1 we c1", 32'(m_we_o), 32'd0);
    check("t1 sel c1", 32'(m_sel_o), 32'hF);
    check("t1 stall c1", 32'(stallreq_if_o), 32'd1);
    cycle();
    check("t1 if_ack c2", 32'(if_ack_o), 32'd1);
    check("t1 if_rdata c2", if_rdata_o, 32'h2402_0005);
    check("t1 stall c2", 32'(stallreq_if_o), 32'd0);
    cycle();
    cycle();

    // Simultaneous requests: data first, fetch in the next idle cycle
    d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h100;
    if_req_i = 1'b1; if_addr_i = 32'h200;
    cycle();
    check("t2 addr c1", m_addr_o, 32'h100);
    check("t2 stall_if c1", 32'(stallreq_if_o), 32'd1);
    cycle();
    check("t2 d_ack c2", 32'(d_ack_o), 32'd1);
    check("t2 d_rdata c2", d_rdata_o, 32'hDEAD_BEEF);
    check("t2 stb c2", 32'(m_stb_o), 32'd0);
    cycle();
    check("t2 fetch stb c3", 32'(m_stb_o), 32'd1);
    check("t2 fetch addr c3", m_addr_o, 32'h200);
    cycle();
    check("t2 if_ack c4", 32'(if_ack_o), 32'd1);
    check("t2 if_rdata c4", if_rdata_o, mem_data(32'h200));
    cycle();

    // Store with two slave wait states
    fixed_ws = 2;
    cycle();
    d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'h3; d_addr_i = 32'h300; d_wdata_i = 32'h1234_5678;
    cycle();
    for (int i = 1; i <= 3; i++) begin
      check("t3 stb", 32'(m_stb_o), 32'd1);
      check("t3 we", 32'(m_we_o), 32'd1);
      check("t3 sel", 32'(m_sel_o), 32'h3);
      check("t3 wdata", m_wdata_o, 32'h1234_5678);
      check("t3 no d_ack", 32'(d_ack_o), 32'd0);
      cycle();
    end
    check("t3 d_ack c4", 32'(d_ack_o), 32'd1);
    check("t3 d_rdata held", d_rdata_o, 32'hDEAD_BEEF);
    cycle();

    // Fetch flushed in its second bus cycle, three wait states
    fixed_ws = 3;
    cycle();
    if_req_i = 1'b1; if_addr_i = 32'h400;
    cycle();
    check("t4 addr c1", m_addr_o, 32'h400);
    cycle();
    flush_i = 1'b1; if_addr_i = 32'h500;
    cycle();
    flush_i = 1'b0;
    cycle();
    check("t4 stb c4", 32'(m_stb_o), 32'd1);
    cycle();
    check("t4 no if_ack c5", 32'(if_ack_o), 32'd0);
    check("t4 if_rdata held c5", if_rdata_o, mem_data(32'h200));
    cycle();
    check("t4 refetch stb c6", 32'(m_stb_o), 32'd1);
    check("t4 refetch addr c6", m_addr_o, 32'h500);
    for (int i = 0; i < 4; i++) cycle();
    check("t4 if_ack c10", 32'(if_ack_o), 32'd1);
    check("t4 if_rdata c10", if_rdata_o, mem_data(32'h500));
    cycle();
    cycle();

    // Reset while a load is on the bus, then a stray acknowledge
    d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h600;
    cycle();
    check("t5 stb c1", 32'(m_stb_o), 32'd1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; d_req_i = 1'b0;
    check("t5 cyc", 32'(m_cyc_o), 32'd0);
    check("t5 stb", 32'(m_stb_o), 32'd0);
    check("t5 sel", 32'(m_sel_o), 32'd0);
    check("t5 addr", m_addr_o, 32'd0);
    check("t5 d_rdata", d_rdata_o, 32'd0);
    check("t5 if_rdata", if_rdata_o, 32'd0);
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    check("t5 late d_ack", 32'(d_ack_o), 32'd0);
    check("t5 late stb", 32'(m_stb_o), 32'd0);
    cycle();

    // Random traffic from both masters with random wait states, flushes and resets
    auto_release = 0;
    rand_ws = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!d_req_i || d_ack_o === 1'b1) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req_i = 1'b1; d_we_i = 1'($urandom_range(0, 1)); d_sel_i = 4'($urandom_range(1, 15));
          d_addr_i = $urandom & 32'hFFFF_FFFC; d_wdata_i = $urandom;
        end else d_req_i = 1'b0;
      end
      if (!if_req_i || if_ack_o === 1'b1) begin
        if ($urandom_range(0, 1) == 0) begin
          if_req_i = 1'b1; if_addr_i = $urandom & 32'hFFFF_FFFC;
        end else if_req_i = 1'b0;
      end
      flush_i = ($urandom_range(0, 15) == 0);
      if (flush_i && if_req_i) if_addr_i = $urandom & 32'hFFFF_FFFC;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; flush_i = 1'b0; d_req_i = 1'b0; if_req_i = 1'b0;
    for (int n = 0; n < 8; n++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
